// File: rtl/pipe_imul.sv
// Pipelined integer multiplier: full-width signed/unsigned product in the first
// stage, followed by LATENCY-1 register stages under valid/ready flow control.
module pipe_imul #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       inflight
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [LATENCY-1:0] stage_valid;
  logic [PW-1:0]      stage_data [LATENCY];
  logic [PW-1:0]      op0_ext;
  logic [PW-1:0]      op1_ext;
  logic [PW-1:0]      product;
  logic               advance;
  logic               in_fire;
  logic               out_fire;
  logic [3:0]         count;

  // A 2W-bit product of the extended operands, taken modulo 2^(2W), is the
  // exact signed or unsigned product, so one multiplier serves both modes.
  always_comb begin
    op0_ext = in_signed ? {{WIDTH{in0[WIDTH-1]}}, in0} : {{WIDTH{1'b0}}, in0};
    op1_ext = in_signed ? {{WIDTH{in1[WIDTH-1]}}, in1} : {{WIDTH{1'b0}}, in1};
    product = op0_ext * op1_ext;
  end

  assign out_valid = stage_valid[LATENCY-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign in_fire   = in_valid && advance;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= '0;
    end else if (advance) begin
      stage_valid <= {stage_valid[LATENCY-1:0], in_valid} >> 0;
    end
  end

  // Data registers need no reset; the output is gated by the valid bit.
  always_ff @(posedge clk) begin
    if (advance) begin
      stage_data[0] <= product;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage_data[i] <= stage_data[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (in_fire && !out_fire) begin
      count <= count + 4'd1;
    end else if (!in_fire && out_fire) begin
      count <= count - 4'd1;
    end
  end

  assign inflight = count;
  assign out      = out_valid ? stage_data[LATENCY-1][WIDTH-1:0]  : '0;
  assign out_hi   = out_valid ? stage_data[LATENCY-1][PW-1:WIDTH] : '0;

endmodule

// File: tb/tb_pipe_imul.sv
// Directed self-checking bench for pipe_imul (WIDTH=32, LATENCY=4).
module tb_pipe_imul;

  localparam int LAT = 4;
  localparam int NV  = 10;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [31:0] out_hi;
  logic [3:0]  inflight;

  int checks = 0;
  int errors = 0;

  vec_t        tbl [NV];
  logic [63:0] sb [$];

  pipe_imul #(.WIDTH(32), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int peak;
    int sent;
    int got;
    logic [63:0] e;

    tbl[0] = '{32'd5,        32'd6,        1'b0, 32'd30,       32'd0};
    tbl[1] = '{32'hFFFFFFFD, 32'd7,        1'b1, 32'hFFFFFFEB, 32'hFFFFFFFF};
    tbl[2] = '{32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFFEB, 32'h00000006};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 32'hFFFFFFFE};
    tbl[4] = '{32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 32'h40000000};
    tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 32'h00000000};
    tbl[6] = '{32'h80000000, 32'd1,        1'b1, 32'h80000000, 32'hFFFFFFFF};
    tbl[7] = '{32'h80000000, 32'd1,        1'b0, 32'h80000000, 32'h00000000};
    tbl[8] = '{32'h12345678, 32'h10,       1'b0, 32'h23456780, 32'h00000001};
    tbl[9] = '{32'd0,        32'hDEADBEEF, 1'b1, 32'h00000000, 32'h00000000};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in0 = '0; in1 = '0; in_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",    64'(out_valid), 64'(0));
    chk("rst_out",      64'(out),       64'(0));
    chk("rst_out_hi",   64'(out_hi),    64'(0));
    chk("rst_inflight", 64'(inflight),  64'(0));
    reset = 1'b0;
    next();
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'(1));

    // Single transaction per vector: latency, value, and bubble afterwards.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in0 = tbl[i].a; in1 = tbl[i].b; in_signed = tbl[i].sgn;
      #1;
      chk("acc_ready", 64'(in_ready), 64'(1));
      next();
      in_valid = 1'b0; in0 = '0; in1 = '0; in_signed = 1'b0;
      for (int c = 1; c <= LAT; c++) begin
        #1;
        chk("lat_valid", 64'(out_valid), 64'(c == LAT));
        if (c == LAT) begin
          chk("vec_lo",      64'(out),      64'(tbl[i].lo));
          chk("vec_hi",      64'(out_hi),   64'(tbl[i].hi));
          chk("vec_inflight", 64'(inflight), 64'(1));
        end
        next();
      end
      #1;
      chk("after_valid",  64'(out_valid), 64'(0));
      chk("after_out",    64'(out),       64'(0));
      chk("after_out_hi", 64'(out_hi),    64'(0));
      chk("after_inflight", 64'(inflight), 64'(0));
    end

    // Three back-to-back pairs.
    peak = 0;
    for (int t = 0; t <= 8; t++) begin
      in_valid = (t < 3); in_signed = 1'b0;
      in0 = 32'(2 * t + 1); in1 = 32'(2 * t + 2);
      #1;
      chk("s3_valid", 64'(out_valid), 64'(t >= 4 && t <= 6));
      if (t == 4) chk("s3_out0", 64'(out), 64'(2));
      if (t == 5) chk("s3_out1", 64'(out), 64'(12));
      if (t == 6) chk("s3_out2", 64'(out), 64'(30));
      if (int'(inflight) > peak) peak = int'(inflight);
      next();
    end
    chk("s3_peak", 64'(peak), 64'(3));

    // Whole table streamed at full rate.
    peak = 0;
    for (int t = 0; t < NV + LAT + 1; t++) begin
      in_valid = (t < NV);
      if (t < NV) begin
        in0 = tbl[t].a; in1 = tbl[t].b; in_signed = tbl[t].sgn;
      end
      #1;
      chk("st_valid", 64'(out_valid), 64'(t >= LAT && t < NV + LAT));
      if (t >= LAT && t < NV + LAT) begin
        chk("st_lo", 64'(out),    64'(tbl[t-LAT].lo));
        chk("st_hi", 64'(out_hi), 64'(tbl[t-LAT].hi));
      end
      if (int'(inflight) > peak) peak = int'(inflight);
      next();
    end
    chk("st_peak", 64'(peak), 64'(LAT));

    // Backpressure: out_ready low for cycles 4..7 with continuous offers.
    sent = 0; got = 0; in_signed = 1'b0;
    for (int t = 0; t < 60 && got < 8; t++) begin
      in_valid = (sent < 8);
      in0 = 32'(sent + 1); in1 = 32'(sent + 3);
      out_ready = !(t >= 4 && t <= 7);
      #1;
      if (t >= 4 && t <= 7) begin
        chk("bp_ready", 64'(in_ready),  64'(0));
        chk("bp_valid", 64'(out_valid), 64'(1));
        chk("bp_hold",  64'(out),       64'(3));
      end
      if (t == 7) chk("bp_inflight", 64'(inflight), 64'(LAT));
      if (in_valid && in_ready) begin
        sb.push_back(64'(sent + 1) * 64'(sent + 3));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("bp_spurious", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("bp_data", {out_hi, out}, e);
        end
        got++;
      end
      next();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    chk("bp_count", 64'(got), 64'(8));
    chk("bp_left",  64'(sb.size()), 64'(0));
    repeat (2) next();

    // Reset while products are in flight.
    for (int t = 0; t <= 9; t++) begin
      reset = (t == 2);
      in_valid = (t < 3) || (t == 4);
      in0 = (t == 4) ? 32'd7 : 32'(t + 1);
      in1 = (t == 4) ? 32'd8 : 32'(t + 2);
      #1;
      if (t == 3) begin
        chk("mr_ready",    64'(in_ready), 64'(1));
        chk("mr_inflight", 64'(inflight), 64'(0));
      end
      if (t >= 3) chk("mr_valid", 64'(out_valid), 64'(t == 8));
      if (t == 8) begin
        chk("mr_out",      64'(out),      64'(56));
        chk("mr_out_hi",   64'(out_hi),   64'(0));
        chk("mr_inflight8", 64'(inflight), 64'(1));
      end
      next();
    end
    reset = 1'b0; in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
